// File: rtl/ad7124_pkg.sv
// Shared definitions for the AD7124 thermocouple scan scheduler:
// FSM encoding, the read-data command byte and the result-word layout.
package ad7124_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_RDY,
        REQ,
        WAIT_RESP,
        WRITE,
        NEXT,
        DONE
    } state_t;

    localparam logic [7:0] AD7124_CMD_RD_DATA = 8'h42;

    localparam int WR_FLAG_BIT = 31;
    localparam int WR_CH_LSB   = 24;
    localparam int WR_CH_W     = 7;
    localparam int WR_DATA_LSB = 0;
    localparam int WR_DATA_W   = 24;

    function automatic logic [31:0] packResult(
        input logic                 flag,
        input logic [WR_CH_W-1:0]   ch,
        input logic [WR_DATA_W-1:0] data
    );
        logic [31:0] word;
        word                              = '0;
        word[WR_FLAG_BIT]                 = flag;
        word[WR_CH_LSB +: WR_CH_W]        = ch;
        word[WR_DATA_LSB +: WR_DATA_W]    = data;
        return word;
    endfunction

endpackage

// File: rtl/ad7124_rdy_sync.sv
// Two-flop synchronizer for the asynchronous DOUT/RDY pin; resets to the
// idle-high level so a reset never looks like a ready conversion.
module ad7124_rdy_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ad7124_tc_scan_scheduler.sv
// Round-robin scanner for AD7124 chips sharing one SPI bus: select a chip,
// wait for RDY (or give up), read the data register and log one result word.
module ad7124_tc_scan_scheduler
    import ad7124_pkg::*;
#(
    parameter int NUM_OF_TC = 8,
    parameter int CS_SETUP  = 4,
    parameter int TIMEOUT   = 1000000,
    localparam int AW = (NUM_OF_TC > 1) ? $clog2(NUM_OF_TC) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    output logic [NUM_OF_TC-1:0] csn,
    input  logic                 sdo_rdy_n,
    output logic                 spi_req_valid,
    input  logic                 spi_req_ready,
    output logic [7:0]           spi_req_cmd,
    input  logic                 spi_resp_valid,
    input  logic [23:0]          spi_resp_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [31:0]          wr_data,
    output logic [NUM_OF_TC-1:0] timeout_err,
    output logic                 scan_done
);

    localparam int SW = $clog2(CS_SETUP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [AW-1:0]        r_ch;
    logic [AW-1:0]        w_nextCh;
    logic [SW-1:0]        r_setupCnt;
    logic [TW-1:0]        r_timeoutCnt;
    logic [31:0]          r_wrData;
    logic [NUM_OF_TC-1:0] r_timeoutErr;
    logic [NUM_OF_TC-1:0] r_csn;
    logic [NUM_OF_TC-1:0] w_csnNext;
    logic                 w_rdyN;
    logic                 w_capture;
    logic                 w_timeoutHit;

    ad7124_rdy_sync u_rdy_sync (
        .i_clk (aclk),
        .i_rst (areset),
        .i_d   (sdo_rdy_n),
        .o_q   (w_rdyN)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // RDY is tested before the timeout so a conversion landing on the last cycle is still read.
    always_comb begin
        w_nextState  = r_state;
        w_nextCh     = r_ch;
        w_capture    = 1'b0;
        w_timeoutHit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_nextState = SELECT;
                    w_nextCh    = '0;
                end
            end
            SELECT: begin
                if (r_setupCnt == SW'(CS_SETUP - 1)) w_nextState = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!w_rdyN) begin
                    w_nextState = REQ;
                end else if (r_timeoutCnt == TW'(TIMEOUT - 1)) begin
                    w_nextState  = WRITE;
                    w_timeoutHit = 1'b1;
                end
            end
            REQ: begin
                if (spi_req_ready) w_nextState = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (spi_resp_valid) begin
                    w_nextState = WRITE;
                    w_capture   = 1'b1;
                end
            end
            WRITE: begin
                w_nextState = NEXT;
            end
            NEXT: begin
                if (r_ch == AW'(NUM_OF_TC - 1)) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = SELECT;
                    w_nextCh    = r_ch + AW'(1);
                end
            end
            DONE: begin
                w_nextState = enable ? SELECT : IDLE;
                w_nextCh    = '0;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_csnNext = '1;
        if (w_nextState inside {SELECT, WAIT_RDY, REQ, WAIT_RESP, WRITE})
            w_csnNext = ~(NUM_OF_TC'(1) << w_nextCh);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ch         <= '0;
            r_csn        <= '1;
            r_setupCnt   <= '0;
            r_timeoutCnt <= '0;
            r_wrData     <= '0;
            r_timeoutErr <= '0;
        end else begin
            r_ch         <= w_nextCh;
            r_csn        <= w_csnNext;
            r_setupCnt   <= (r_state == SELECT && w_nextState == SELECT)
                            ? r_setupCnt + SW'(1) : '0;
            r_timeoutCnt <= (r_state == WAIT_RDY && w_nextState == WAIT_RDY)
                            ? r_timeoutCnt + TW'(1) : '0;
            if (w_capture) begin
                r_wrData           <= packResult(1'b0, 7'(r_ch), spi_resp_data);
                r_timeoutErr[r_ch] <= 1'b0;
            end else if (w_timeoutHit) begin
                r_wrData           <= packResult(1'b1, 7'(r_ch), 24'h0);
                r_timeoutErr[r_ch] <= 1'b1;
            end
        end
    end

    assign csn           = r_csn;
    assign spi_req_valid = (r_state == REQ);
    assign spi_req_cmd   = AD7124_CMD_RD_DATA;
    assign wr_en         = (r_state == WRITE);
    assign wr_addr       = r_ch;
    assign wr_data       = r_wrData;
    assign timeout_err   = r_timeoutErr;
    assign scan_done     = (r_state == DONE);

endmodule

// File: doc/ad7124_tc_scan_scheduler.md
AD7124_TC_SCAN_SCHEDULER -- requirements
Module: ad7124_tc_scan_scheduler

Interface
REQ-001 Parameter NUM_OF_TC, default 8: number of AD7124 chips sharing one TC SPI bus on a board.
REQ-002 Parameter CS_SETUP, default 4: aclk cycles from CSN assertion to RDY sampling.
REQ-003 Parameter TIMEOUT, default 1000000: aclk cycles allowed for RDY before the channel is abandoned.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 aclk  in  1  clock.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 enable  in  1  level; continuous scanning while high.
REQ-008 csn  out  NUM_OF_TC  active-low chip selects; at most one bit low.
REQ-009 sdo_rdy_n  in  1  raw DOUT/RDY pin; low means conversion ready.
REQ-010 spi_req_valid / spi_req_ready  out / in  1 / 1  request handshake to the shared SPI engine.
REQ-011 spi_req_cmd  out  8  command byte, constant 0x42 (read the data register).
REQ-012 spi_resp_valid  in  1  one-cycle pulse with the response.
REQ-013 spi_resp_data  in  24  conversion result.
REQ-014 wr_en  out  1  one-cycle result-write strobe to the BRAM port.
REQ-015 wr_addr  out  clog2(NUM_OF_TC)  channel index.
REQ-016 wr_data  out  32  [31] timeout flag, [30:24] channel index, [23:0] data.
REQ-017 timeout_err  out  NUM_OF_TC  per-channel sticky timeout status.
REQ-018 scan_done  out  1  one-cycle pulse at the end of each full scan; drives the IRQ.

Function
REQ-019 The FSM SHALL use the states IDLE, SELECT, WAIT_RDY, REQ, WAIT_RESP, WRITE, NEXT and DONE.
REQ-020 IDLE->SELECT when enable=1; the channel counter SHALL be set to 0 and csn[ch] SHALL be driven low on entry to SELECT.
REQ-021 SELECT SHALL hold for exactly CS_SETUP cycles, then go to WAIT_RDY; the timeout counter SHALL be cleared.
REQ-022 sdo_rdy_n SHALL pass through a 2-flop synchronizer; WAIT_RDY->REQ on synchronized low.
REQ-023 When the timeout counter reaches TIMEOUT-1 in WAIT_RDY: go to WRITE with flag=1 and data=0, and set timeout_err[ch].
REQ-024 If RDY and timeout occur in the same cycle, RDY SHALL win.
REQ-025 In REQ, spi_req_valid SHALL be held high until spi_req_ready; the transfer completes on valid&ready, then go to WAIT_RESP; valid SHALL NOT drop before ready.
REQ-026 WAIT_RESP->WRITE on spi_resp_valid: capture data, set flag=0, and clear timeout_err[ch].
REQ-027 In WRITE, wr_en=1 for exactly one cycle with wr_addr=ch; the state SHALL then go to NEXT.
REQ-028 NEXT SHALL deassert all csn for one cycle; if ch=NUM_OF_TC-1 go to DONE, else ch+1 and go to SELECT.
REQ-029 DONE SHALL pulse scan_done for one cycle, then go to SELECT with ch=0 if enable=1, else to IDLE.
REQ-030 If enable falls mid-scan, the current scan SHALL complete through DONE (no partial scan), then return to IDLE.
REQ-031 Per-channel worst-case time SHALL be CS_SETUP + TIMEOUT + SPI latency + 3 cycles.

Reset
REQ-032 On reset, all outputs SHALL go to their reset values immediately (asynchronous): csn all ones, spi_req_valid=0, wr_en=0, wr_addr=0, wr_data=0, scan_done=0, timeout_err=0, state IDLE, counters 0.
REQ-033 On reset mid-transfer, any later spi_resp_valid SHALL be ignored while in IDLE.

Structure
REQ-034 Package ad7124_pkg SHALL hold the FSM state encoding, the AD7124_CMD_RD_DATA=8'h42 constant and the wr_data field positions.
REQ-035 Sub-module ad7124_rdy_sync (the 2-flop synchronizer with async reset to 1) SHALL be a separate instance.

Verification
REQ-036 enable=1, RDY low 10 cycles after SELECT, resp 0xABCDEF on every channel -> 8 writes, addr 0..7, wr_data=0x00ABCDEF|(ch<<24), then one scan_done pulse.
REQ-037 Channel 3 RDY never low, TIMEOUT=100 -> entry at addr 3 = 0x83000000 after 100 WAIT_RDY cycles, timeout_err=0x08, scan continues to ch 4; the next good read clears bit 3.
REQ-038 spi_req_ready stalled 20 cycles -> valid stays high with cmd 0x42 throughout, exactly one handshake.
REQ-039 enable dropped during ch 2 -> channels 2..7 still written, scan_done pulses, then IDLE with csn=all ones.
REQ-040 areset asserted in WAIT_RESP -> csn=all ones in the same cycle, then a stray resp_valid produces no wr_en.
REQ-041 RDY low and timeout in the same cycle -> normal read path, flag=0.
